// File: rtl/sbi_burst_arbiter.sv
// sbi_burst_arbiter: two-requester burst arbiter and sequencer in front of an
// SBI memory slave. It latches the winner's burst descriptor, issues one SBI
// beat per cycle, steers read data back to the owner and pulses done_o.
// Build option: define SBI_ARB_FIXED_PRIO_EN to make requester 0 always win
// ties. Without it, ties are resolved round-robin.

module sbi_burst_arbiter #(
  parameter int Width  = 32,
  parameter int Depth  = 256,
  parameter int MaxLen = 16,
  parameter int Aw     = $clog2(Depth),
  parameter int Lw     = $clog2(MaxLen + 1)
) (
  input  logic                 bCLK,
  input  logic                 bRST,
  input  logic [1:0]           req_i,
  input  logic [1:0]           write_i,
  input  logic [2*Aw-1:0]      addr_i,
  input  logic [2*Lw-1:0]      len_i,
  input  logic [2*Width-1:0]   wdata_i,
  output logic [1:0]           gnt_o,
  output logic [1:0]           beat_o,
  output logic [Width-1:0]     rdata_o,
  output logic [1:0]           rvalid_o,
  output logic [1:0]           done_o,
  output logic [Aw-1:0]        bADDR,
  output logic                 bSTART,
  output logic                 bACCESS,
  output logic                 bWRITE,
  output logic [Width-1:0]     bD,
  input  logic [Width-1:0]     bQ,
  input  logic                 bVALID
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic            r_owner;
  logic            r_write;
  logic [Aw-1:0]   r_addr;
  logic [Lw-1:0]   r_len;
  logic [Lw-1:0]   r_count;
  logic [1:0]      r_done;

  logic            w_winner;
  logic [Lw-1:0]   w_reqLen;
  logic [Lw-1:0]   w_effLen;
  logic            w_lastBeat;

`ifdef SBI_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 wins whenever it is requesting.
  always_comb begin
    w_winner = ~req_i[0];
  end
`else
  logic r_last;

  // Round-robin pick: on a tie the requester not granted last time wins.
  always_comb begin
    w_winner = ~req_i[0];
    if (req_i == 2'b11) begin
      w_winner = ~r_last;
    end
  end

  // Remember the most recent grant so the next tie goes the other way.
  always_ff @(posedge bCLK) begin
    if (bRST) begin
      r_last <= 1'b1;
    end else if (r_state == IDLE && (|req_i)) begin
      r_last <= w_winner;
    end
  end
`endif

  // Clamp the winner's requested length into 1..MaxLen beats.
  always_comb begin
    w_reqLen = w_winner ? len_i[2*Lw-1:Lw] : len_i[Lw-1:0];
    w_effLen = w_reqLen;
    if (w_reqLen == '0) begin
      w_effLen = Lw'(1);
    end else if (w_reqLen > Lw'(MaxLen)) begin
      w_effLen = Lw'(MaxLen);
    end
  end

  assign w_lastBeat = (r_count == (r_len - 1'b1));

  // Next-state logic: a write returns straight to IDLE, a read drains one cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (|req_i) begin
          w_nextState = BURST;
        end
      end
      BURST: begin
        if (w_lastBeat) begin
          w_nextState = r_write ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register, descriptor latch, beat counter and completion pulse.
  always_ff @(posedge bCLK) begin
    if (bRST) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_len   <= '0;
      r_count <= '0;
      r_done  <= '0;
    end else begin
      r_state <= w_nextState;
      r_done  <= '0;
      case (r_state)
        IDLE: begin
          if (|req_i) begin
            r_owner <= w_winner;
            r_write <= w_winner ? write_i[1] : write_i[0];
            r_addr  <= w_winner ? addr_i[2*Aw-1:Aw] : addr_i[Aw-1:0];
            r_len   <= w_effLen;
            r_count <= '0;
          end
        end
        BURST: begin
          r_addr  <= r_addr + 1'b1;
          r_count <= r_count + 1'b1;
          if (w_lastBeat && r_write) begin
            r_done[r_owner] <= 1'b1;
          end
        end
        DRAIN: begin
          r_done[r_owner] <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // SBI master drive, grant, write-beat handshake and read-valid steering.
  always_comb begin
    gnt_o    = '0;
    beat_o   = '0;
    rvalid_o = '0;
    bSTART   = 1'b0;
    bACCESS  = 1'b0;
    bWRITE   = 1'b0;
    bADDR    = '0;
    bD       = '0;
    if (r_state != IDLE) begin
      gnt_o[r_owner] = 1'b1;
    end
    if (r_state == BURST) begin
      bACCESS = 1'b1;
      bWRITE  = r_write;
      bADDR   = r_addr;
      bSTART  = (r_count == '0);
      if (r_write) begin
        bD             = r_owner ? wdata_i[2*Width-1:Width] : wdata_i[Width-1:0];
        beat_o[r_owner] = 1'b1;
      end
    end
    if ((r_state == BURST && !r_write) || r_state == DRAIN) begin
      rvalid_o[r_owner] = bVALID;
    end
  end

  assign rdata_o = bQ;
  assign done_o  = r_done;

endmodule

// File: tb/tb_sbi_burst_arbiter.sv
// tb_sbi_burst_arbiter: directed bench for sbi_burst_arbiter with a small
// behavioural SBI memory slave (1-cycle read latency). Single-requester bursts
// come from a vector table; ties, mid-burst reset, requester drop and stray
// bVALID are hand-written sequences.

module tb_sbi_burst_arbiter;

  logic         bCLK = 1'b0;
  logic         bRST;
  logic [1:0]   req_i;
  logic [1:0]   write_i;
  logic [15:0]  addr_i;
  logic [9:0]   len_i;
  logic [63:0]  wdata_i;
  logic [1:0]   gnt_o;
  logic [1:0]   beat_o;
  logic [31:0]  rdata_o;
  logic [1:0]   rvalid_o;
  logic [1:0]   done_o;
  logic [7:0]   bADDR;
  logic         bSTART;
  logic         bACCESS;
  logic         bWRITE;
  logic [31:0]  bD;
  logic [31:0]  bQ = '0;
  logic         bVALID = 1'b0;

  logic [31:0]  mem [256];
  logic         forceValid;
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  int           wIdx [2];
  logic [1:0]   pendAdv;

  typedef struct {
    logic [1:0]  req;
    logic        wr;
    logic [7:0]  addr;
    logic [4:0]  len;
    int          expBeats;
    logic [7:0]  expFirst;
    logic [7:0]  expLast;
    int          expDoneOfs;
    logic [31:0] expData0;
  } vec_t;

  vec_t vecs [9];

  sbi_burst_arbiter dut (
    .bCLK     (bCLK),
    .bRST     (bRST),
    .req_i    (req_i),
    .write_i  (write_i),
    .addr_i   (addr_i),
    .len_i    (len_i),
    .wdata_i  (wdata_i),
    .gnt_o    (gnt_o),
    .beat_o   (beat_o),
    .rdata_o  (rdata_o),
    .rvalid_o (rvalid_o),
    .done_o   (done_o),
    .bADDR    (bADDR),
    .bSTART   (bSTART),
    .bACCESS  (bACCESS),
    .bWRITE   (bWRITE),
    .bD       (bD),
    .bQ       (bQ),
    .bVALID   (bVALID)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 bCLK = ~bCLK;

  // Cycle counter used to measure latencies relative to the request cycle.
  always @(posedge bCLK) cyc <= cyc + 1;

  // Behavioural SBI slave: writes on the beat, read data one cycle later.
  always @(posedge bCLK) begin
    if (bACCESS && bWRITE) mem[bADDR] <= bD;
    bQ     <= mem[bADDR];
    bVALID <= (bACCESS && !bWRITE) || forceValid;
  end

  // Compare one value and log a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present each requester's current write word (base + beats consumed).
  task automatic updateWdata();
    wdata_i[31:0]  = 32'hA0 + wIdx[0];
    wdata_i[63:32] = 32'hB0 + wIdx[1];
  endtask

  // Move past the next rising edge and advance write data for consumed beats.
  task automatic stepCycle();
    @(posedge bCLK);
    #1;
    for (int k = 0; k < 2; k++) if (pendAdv[k]) wIdx[k]++;
    pendAdv = '0;
    updateWdata();
  endtask

  // Hold synchronous reset for two edges, checking idle outputs during reset.
  task automatic doReset(input bit check);
    bRST = 1'b1;
    req_i = '0;
    forceValid = 1'b0;
    @(posedge bCLK);
    @(negedge bCLK);
    if (check) begin
      checkOutput("reset ctrl", {23'd0, gnt_o, beat_o, rvalid_o, done_o, bSTART}, 32'd0);
      checkOutput("reset bus", {22'd0, bACCESS, bWRITE, bADDR}, 32'd0);
      checkOutput("reset bD", bD, 32'd0);
    end
    @(posedge bCLK);
    #1;
    bRST = 1'b0;
  endtask

  // Wait for done_o with a cycle budget, then release all requests.
  task automatic waitDone(input string name);
    bit found;
    found = 1'b0;
    for (int t = 0; t < 30 && !found; t++) begin
      @(negedge bCLK);
      pendAdv = beat_o;
      if (done_o != 2'b00) begin
        found = 1'b1;
        req_i = '0;
      end
      stepCycle();
    end
    checkOutput({name, " done seen"}, {31'd0, found}, 32'd1);
  endtask

  // Run one table vector as a single-requester burst and check everything.
  task automatic applyStimulus(input int idx, input vec_t v);
    int         c0, beats, starts, startOfs, pulses, rv, rvOfs, doneOfs;
    logic [1:0] gntSeen, doneOwner, gntAtDone;
    logic [7:0] firstAddr, lastAddr, nextAddr;
    bit         addrOk, dataOk, rvOwnerOk, finished;
    string      p;
    p = $sformatf("vec%0d", idx);
    beats = 0; starts = 0; startOfs = -1; pulses = 0; rv = 0; rvOfs = -1; doneOfs = -1;
    gntSeen = '0; doneOwner = '0; gntAtDone = '0;
    firstAddr = '0; lastAddr = '0; nextAddr = '0;
    addrOk = 1'b1; dataOk = 1'b1; rvOwnerOk = 1'b1; finished = 1'b0;
    stepCycle();
    c0 = cyc;
    for (int k = 0; k < 2; k++) begin
      if (v.req[k]) begin
        write_i[k]       = v.wr;
        addr_i[k*8 +: 8] = v.addr;
        len_i[k*5 +: 5]  = v.len;
        wIdx[k]          = 0;
      end
    end
    updateWdata();
    req_i = v.req;
    for (int t = 0; t < 40 && !finished; t++) begin
      @(negedge bCLK);
      pendAdv = beat_o;
      if (bACCESS) begin
        if (beats == 0) firstAddr = bADDR;
        else if (bADDR != nextAddr) addrOk = 1'b0;
        nextAddr = bADDR + 8'd1;
        lastAddr = bADDR;
        beats++;
      end
      if (bSTART) begin
        starts++;
        if (starts == 1) startOfs = cyc - c0;
      end
      pulses += $countones(beat_o);
      if (rvalid_o != 2'b00) begin
        if (rv == 0) rvOfs = cyc - c0;
        if (rvalid_o != v.req) rvOwnerOk = 1'b0;
        if (rdata_o != v.expData0 + rv) dataOk = 1'b0;
        rv++;
      end
      gntSeen |= gnt_o;
      if (done_o != 2'b00) begin
        doneOfs   = cyc - c0;
        doneOwner = done_o;
        gntAtDone = gnt_o;
        req_i     = '0;
        finished  = 1'b1;
      end
      stepCycle();
    end
    checkOutput({p, " finished"}, {31'd0, finished}, 32'd1);
    checkOutput({p, " beats"}, beats, v.expBeats);
    checkOutput({p, " first addr"}, {24'd0, firstAddr}, {24'd0, v.expFirst});
    checkOutput({p, " last addr"}, {24'd0, lastAddr}, {24'd0, v.expLast});
    checkOutput({p, " addr step"}, {31'd0, addrOk}, 32'd1);
    checkOutput({p, " bSTART count"}, starts, 1);
    checkOutput({p, " bSTART ofs"}, startOfs, 1);
    checkOutput({p, " gnt owner"}, {30'd0, gntSeen}, {30'd0, v.req});
    checkOutput({p, " done ofs"}, doneOfs, v.expDoneOfs);
    checkOutput({p, " done owner"}, {30'd0, doneOwner}, {30'd0, v.req});
    checkOutput({p, " gnt at done"}, {30'd0, gntAtDone}, 32'd0);
    checkOutput({p, " beat_o pulses"}, pulses, v.wr ? v.expBeats : 0);
    checkOutput({p, " rvalid count"}, rv, v.wr ? 0 : v.expBeats);
    if (!v.wr) begin
      checkOutput({p, " rvalid ofs"}, rvOfs, 2);
      checkOutput({p, " rvalid owner"}, {31'd0, rvOwnerOk}, 32'd1);
      checkOutput({p, " rdata"}, {31'd0, dataOk}, 32'd1);
    end
  endtask

  // Main test sequence.
  initial begin
    int         c0, nStart, lastDone, beats, rv, doneOfs, doneSeen;
    logic [7:0] lastAddr;
    logic [1:0] expOrder [4];

    req_i = '0; write_i = '0; addr_i = '0; len_i = '0; wdata_i = '0;
    forceValid = 1'b0; pendAdv = '0; wIdx[0] = 0; wIdx[1] = 0;

    //            req    wr    addr   len    beats first  last  done data0
    vecs[0] = '{2'b01, 1'b1, 8'h10, 5'd4,  4,  8'h10, 8'h13, 5,  32'h0};
    vecs[1] = '{2'b01, 1'b0, 8'h10, 5'd3,  3,  8'h10, 8'h12, 5,  32'hA0};
    vecs[2] = '{2'b10, 1'b1, 8'hFE, 5'd4,  4,  8'hFE, 8'h01, 5,  32'h0};
    vecs[3] = '{2'b10, 1'b1, 8'h40, 5'd0,  1,  8'h40, 8'h40, 2,  32'h0};
    vecs[4] = '{2'b01, 1'b1, 8'h50, 5'd21, 16, 8'h50, 8'h5F, 17, 32'h0};
    vecs[5] = '{2'b01, 1'b0, 8'hFE, 5'd4,  4,  8'hFE, 8'h01, 6,  32'hB0};
    vecs[6] = '{2'b10, 1'b0, 8'h50, 5'd21, 16, 8'h50, 8'h5F, 18, 32'hA0};
    vecs[7] = '{2'b10, 1'b0, 8'h40, 5'd0,  1,  8'h40, 8'h40, 3,  32'hB0};
    vecs[8] = '{2'b01, 1'b1, 8'h60, 5'd16, 16, 8'h60, 8'h6F, 17, 32'h0};

`ifdef SBI_ARB_FIXED_PRIO_EN
    expOrder = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    expOrder = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif

    $display("[TB] reset and idle outputs");
    doReset(1'b1);

    $display("[TB] table-driven single-requester bursts");
    for (int i = 0; i < 9; i++) applyStimulus(i, vecs[i]);

    $display("[TB] stray bVALID while idle");
    stepCycle();
    forceValid = 1'b1;
    stepCycle();
    forceValid = 1'b0;
    @(negedge bCLK);
    checkOutput("stray bVALID rvalid_o", {30'd0, rvalid_o}, 32'd0);

    $display("[TB] tie between both requesters");
    doReset(1'b0);
    stepCycle();
    c0 = cyc;
    write_i = 2'b11;
    addr_i  = {8'h90, 8'h80};
    len_i   = {5'd2, 5'd2};
    wIdx[0] = 0; wIdx[1] = 0;
    updateWdata();
    req_i = 2'b11;
    nStart = 0;
    lastDone = -100;
    for (int t = 0; t < 40 && nStart < 4; t++) begin
      @(negedge bCLK);
      pendAdv = beat_o;
      if (bSTART) begin
        checkOutput($sformatf("tie burst%0d owner", nStart), {30'd0, gnt_o}, {30'd0, expOrder[nStart]});
        if (nStart == 0) checkOutput("tie first start ofs", cyc - c0, 1);
        else checkOutput($sformatf("tie burst%0d start after done", nStart), cyc - lastDone, 1);
        nStart++;
      end
      if (done_o != 2'b00) lastDone = cyc;
      stepCycle();
    end
    checkOutput("tie burst count", nStart, 4);
    req_i = '0;
    waitDone("tie tail");

    $display("[TB] reset in the middle of a write burst");
    stepCycle();
    write_i[0]   = 1'b1;
    addr_i[7:0]  = 8'h20;
    len_i[4:0]   = 5'd8;
    req_i = 2'b01;
    stepCycle();
    stepCycle();
    checkOutput("rst-mid beat2 active", {31'd0, bACCESS}, 32'd1);
    bRST = 1'b1;
    stepCycle();
    bRST  = 1'b0;
    req_i = '0;
    @(negedge bCLK);
    checkOutput("rst-mid ctrl", {23'd0, gnt_o, beat_o, rvalid_o, done_o, bSTART}, 32'd0);
    checkOutput("rst-mid bus", {22'd0, bACCESS, bWRITE, bADDR}, 32'd0);
    checkOutput("rst-mid bD", bD, 32'd0);
    doneSeen = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge bCLK);
      if (done_o != 2'b00) doneSeen++;
    end
    checkOutput("rst-mid no done", doneSeen, 0);
    stepCycle();
    write_i[1]    = 1'b1;
    addr_i[15:8]  = 8'h30;
    len_i[9:5]    = 5'd1;
    req_i = 2'b10;
    stepCycle();
    @(negedge bCLK);
    checkOutput("post-rst gnt", {30'd0, gnt_o}, 32'd2);
    checkOutput("post-rst bSTART", {31'd0, bSTART}, 32'd1);
    stepCycle();
    waitDone("post-rst");

    $display("[TB] requester drops req mid read burst");
    stepCycle();
    c0 = cyc;
    write_i[0]  = 1'b0;
    addr_i[7:0] = 8'h10;
    len_i[4:0]  = 5'd4;
    req_i = 2'b01;
    beats = 0; rv = 0; doneOfs = -1; lastAddr = '0;
    for (int t = 0; t < 20 && doneOfs < 0; t++) begin
      @(negedge bCLK);
      if (bACCESS) begin
        beats++;
        lastAddr = bADDR;
      end
      if (rvalid_o[0]) rv++;
      if (done_o[0]) doneOfs = cyc - c0;
      stepCycle();
      if (cyc - c0 == 1) begin
        req_i       = '0;
        addr_i[7:0] = 8'h70;
        len_i[4:0]  = 5'd1;
      end
    end
    checkOutput("drop beats", beats, 4);
    checkOutput("drop last addr", {24'd0, lastAddr}, 32'h13);
    checkOutput("drop rvalid count", rv, 4);
    checkOutput("drop done ofs", doneOfs, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sbi_burst_arbiter.md
# sbi_burst_arbiter

Two-requester burst arbiter and sequencer for the SBI memory slave (SBI interface plus single-port RAM). Each requester posts a burst descriptor (start address, length, direction). The block grants one requester at a time, round-robin, and drives the SBI master pins beat-by-beat. It returns read data to the owner and signals completion, so several engines can share one SBI memory without protocol collisions.

## Interface
- Width, 32: data width, matches the SBI slave.
- Depth, 256: memory depth in words; Aw = $clog2(Depth).
- MaxLen, 16: maximum beats per burst; Lw = $clog2(MaxLen+1).

Ports:
- bCLK  in  1  single clock; all logic on rising edge.
- bRST  in  1  reset, synchronous, active-high.
- req_i  in  2  per-requester burst request; held until done_o.
- write_i  in  2  per-requester direction, 1 = write.
- addr_i  in  2×Aw  per-requester start word address.
- len_i  in  2×Lw  per-requester beat count.
- wdata_i  in  2×Width  per-requester write data for the current beat.
- gnt_o  out  2  one-hot, high for the whole owned burst incl. drain.
- beat_o  out  2  write beat consumed this cycle; requester advances wdata.
- rdata_o  out  Width  read data, equal to bQ.
- rvalid_o  out  2  bVALID steered to the read owner.
- done_o  out  2  one-cycle burst-complete pulse.
- bADDR  out  Aw, bSTART out 1, bACCESS out 1, bWRITE out 1, bD out Width: SBI master drive.
- bQ  in  Width, bVALID  in  1: SBI read return, 1 cycle after the read beat.

## Operation
- FSM states: IDLE, BURST, DRAIN.
- **IDLE:**
  - With no req_i high, stay.
  - Otherwise select a winner and latch owner, write, addr and length.
  - Effective length: len 0 becomes 1; len > MaxLen becomes MaxLen.
  - Go to BURST.
- **Arbitration:**
  - Round-robin. When both requesters are high, the one not granted last wins.
  - The last-granted pointer resets to 1, so requester 0 wins the first tie.
- **BURST:**
  - One beat per cycle: bACCESS=1, bWRITE=latched direction, bADDR=current address.
  - bSTART=1 on the first beat only.
  - Address increments by 1 per beat and wraps modulo Depth (Depth-1 → 0).
  - Writes: bD = wdata_i[owner] (combinational); beat_o[owner]=1 on every beat.
  - After the last beat:
    - a write goes to IDLE with done_o[owner] pulsing in that IDLE cycle;
    - a read goes to DRAIN.
- **DRAIN:** one cycle to absorb the final bVALID; then IDLE, with done_o pulsing in the IDLE cycle.
- **Read return:** rdata_o = bQ; rvalid_o[owner] = bVALID while a read burst is active or draining. bVALID at any other time is ignored.
- **Dropping req_i mid-burst:** ignored. The burst completes and done_o still pulses.
- **Descriptor changes after the grant:** ignored, because the descriptor is latched in IDLE.

## Timing
- Reset values: gnt_o, beat_o, rvalid_o, done_o, bSTART, bACCESS, bWRITE = 0; bADDR = 0; bD = 0; FSM = IDLE; pointer = 1.
- Reset mid-burst aborts immediately. Outputs take their reset values next cycle and no done_o pulses.
- Grant and beats: req_i seen in IDLE at cycle 0 → gnt_o and first beat (bSTART) at cycle 1 → beats at cycles 1..N.
- Write completion: done_o at cycle N+1.
- Read completion:
  - rvalid_o at cycles 2..N+1;
  - DRAIN at cycle N+1;
  - done_o at cycle N+2.
- Back-to-back: arbitration runs in the done_o cycle, so the next burst starts one cycle after done_o (minimum one idle cycle between bursts).
- gnt_o falls in the done_o cycle.

## Configuration
- SBI_ARB_FIXED_PRIO_EN defined: fixed priority, requester 0 always wins ties; the pointer is unused. Requester 1 can starve.
- SBI_ARB_FIXED_PRIO_EN undefined: round-robin as described above.

## Test plan
- Single write: req0, addr 0x10, len 4, data A0..A3. Expected:
  - bSTART at cycle 1;
  - bADDR 0x10..0x13 at cycles 1..4;
  - beat_o[0] ×4;
  - done_o[0] at cycle 5;
  - reading back returns A0..A3.
- Single read, len 3 from 0x10: rvalid_o[0] at cycles 2..4 with A0..A2; done_o[0] at cycle 5; gnt_o[1] stays 0 throughout.
- Tie: req0 and req1 held continuously, len 2 writes. Expected:
  - grants alternate 0,1,0,1;
  - each new bSTART is exactly 1 cycle after the previous done_o;
  - with SBI_ARB_FIXED_PRIO_EN, only requester 0 is granted.
- Wrap and clamp:
  - addr Depth-2, len 4: bADDR sequence Depth-2, Depth-1, 0, 1;
  - len 0: exactly 1 beat;
  - len MaxLen+5: exactly MaxLen beats.
- Reset mid-burst: bRST at beat 2 of a len 8 write. Next cycle all outputs are 0 and no done_o pulses. After reset, req1 alone is granted at cycle 1.
- Requester drop: req0 deasserted at beat 1 of a len 4 read. All 4 beats are issued and done_o[0] still pulses.
